// File: rtl/eth_stats_sched_pkg.sv
// Shared constants, helper function and FSM encoding for the stats scheduler.
package eth_stats_sched_pkg;

  localparam int unsigned REC_W = 64;

  // Port-index width; a single port still needs one bit.
  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/eth_stats_sched_if.sv
// Collector-side record streams plus the merged AXIS output.
interface eth_stats_sched_if
  import eth_stats_sched_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = REC_W,
  parameter int unsigned IW = id_w(N)
);

  logic [N-1:0]    s_tvalid;
  logic [N-1:0]    s_tlast;
  logic [N*DW-1:0] s_tdata;
  logic [N-1:0]    s_tready;

  logic            m_tvalid;
  logic            m_tready;
  logic [DW-1:0]   m_tdata;
  logic            m_tlast;
  logic [IW-1:0]   m_tdest;

  modport master (
    input  s_tvalid, s_tlast, s_tdata, m_tready,
    output s_tready, m_tvalid, m_tdata, m_tlast, m_tdest
  );

  modport slave (
    output s_tvalid, s_tlast, s_tdata, m_tready,
    input  s_tready, m_tvalid, m_tdata, m_tlast, m_tdest
  );

endinterface

// File: rtl/eth_stats_sched_rr_arbiter.sv
// Combinational rotating-priority arbiter: first request at or after ptr wins.
module eth_stats_sched_rr_arbiter
  import eth_stats_sched_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = id_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  // Scan ports starting at ptr, wrapping, and take the first requester.
  always_comb begin
    int          pos;
    logic [IW-1:0] cand;
    logic        found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    cand  = '0;
    for (int k = 0; k < int'(N); k++) begin
      pos = int'(ptr) + k;
      if (pos >= int'(N)) pos = pos - int'(N);
      cand = IW'(pos);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/eth_stats_sched.sv
// Periodic sample scheduler plus round-robin merge of collector record streams.
module eth_stats_sched
  import eth_stats_sched_pkg::*;
#(
  parameter  int unsigned C_NUM_PORTS  = 4,
  parameter  int unsigned C_DATA_WIDTH = REC_W,
  parameter  int unsigned C_PERIOD_W   = 32,
  parameter  int unsigned C_OVR_W      = 16,
  localparam int unsigned ID_W         = id_w(C_NUM_PORTS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [C_PERIOD_W-1:0]   sample_period,
  input  logic                    time_running,
  output logic [C_NUM_PORTS-1:0]  sample_req,
  eth_stats_sched_if.master       bus,
  output logic [C_OVR_W-1:0]      overrun_count
);

  logic [C_PERIOD_W-1:0]   cnt;
  logic                    run_c;
  logic                    fire_c;
  logic [C_NUM_PORTS-1:0]  pending;
  logic [C_NUM_PORTS-1:0]  done_c;
  logic                    ovr_evt_c;
  logic [C_NUM_PORTS-1:0]  arb_gnt;
  logic [ID_W-1:0]         arb_idx;
  arb_state_t              state, state_n;
  logic [ID_W-1:0]         g, g_n;
  logic [ID_W-1:0]         rr_ptr, rr_n;
  logic                    slot_free_c;
  logic                    take_c;
  logic [C_DATA_WIDTH-1:0] sel_data_c;

  // Ge compare lets a shortened period fire immediately.
  assign run_c  = enable && time_running && (sample_period != '0);
  assign fire_c = run_c && (cnt >= (sample_period - C_PERIOD_W'(1)));

  // Period counter and the sample pulse one cycle after the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      sample_req <= '0;
    end else begin
      sample_req <= {C_NUM_PORTS{fire_c}};
      if (!enable)     cnt <= '0;
      else if (fire_c) cnt <= '0;
      else if (run_c)  cnt <= cnt + C_PERIOD_W'(1);
    end
  end

  // A port completes its pending record on the handshake of its last beat.
  assign done_c    = bus.s_tvalid & bus.s_tready & bus.s_tlast;
  assign ovr_evt_c = sample_req[0] && (|(pending & ~done_c));

  // Pending mask and saturating overrun counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending       <= '0;
      overrun_count <= '0;
    end else begin
      pending <= (pending & ~done_c) | {C_NUM_PORTS{sample_req[0]}};
      if (ovr_evt_c && (overrun_count != '1))
        overrun_count <= overrun_count + C_OVR_W'(1);
    end
  end

  eth_stats_sched_rr_arbiter #(.N(C_NUM_PORTS)) u_arb (
    .req (bus.s_tvalid),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // Arbiter state, latched grant and rotation pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      g      <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_n;
      g      <= g_n;
      rr_ptr <= rr_n;
    end
  end

  // Grant selection in IDLE; grant held for the whole record in BUSY.
  always_comb begin
    state_n      = state;
    g_n          = g;
    rr_n         = rr_ptr;
    take_c       = 1'b0;
    bus.s_tready = '0;
    slot_free_c  = !bus.m_tvalid || bus.m_tready;
    unique case (state)
      ST_IDLE: begin
        if (|arb_gnt) begin
          g_n     = arb_idx;
          state_n = ST_BUSY;
        end
      end
      ST_BUSY: begin
        bus.s_tready[g] = slot_free_c;
        take_c          = slot_free_c && bus.s_tvalid[g];
        if (take_c && bus.s_tlast[g]) begin
          rr_n    = (g == ID_W'(C_NUM_PORTS - 1)) ? '0 : g + ID_W'(1);
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Data of the granted port.
  always_comb begin
    sel_data_c = '0;
    for (int i = 0; i < int'(C_NUM_PORTS); i++) begin
      if (g == ID_W'(i)) sel_data_c = bus.s_tdata[i*C_DATA_WIDTH +: C_DATA_WIDTH];
    end
  end

  // Single-stage output register; payload holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.m_tvalid <= 1'b0;
      bus.m_tdata  <= '0;
      bus.m_tlast  <= 1'b0;
      bus.m_tdest  <= '0;
    end else if (take_c) begin
      bus.m_tvalid <= 1'b1;
      bus.m_tdata  <= sel_data_c;
      bus.m_tlast  <= bus.s_tlast[g];
      bus.m_tdest  <= g;
    end else if (bus.m_tready) begin
      bus.m_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_eth_stats_sched.sv
// Self-checking bench: sampling timing, overrun counting, fairness, backpressure, reset.
module tb_eth_stats_sched;
  import eth_stats_sched_pkg::*;

  localparam int unsigned NP = 4;
  localparam int unsigned DW = 64;
  localparam int unsigned PW = 32;
  localparam int unsigned OW = 16;
  localparam int unsigned IW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          time_running;
  logic [PW-1:0] sample_period;
  logic [NP-1:0] sample_req;
  logic [OW-1:0] overrun_count;

  eth_stats_sched_if #(.N(NP), .DW(DW), .IW(IW)) bus ();

  eth_stats_sched #(
    .C_NUM_PORTS (NP),
    .C_DATA_WIDTH(DW),
    .C_PERIOD_W  (PW),
    .C_OVR_W     (OW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .sample_period(sample_period),
    .time_running (time_running),
    .sample_req   (sample_req),
    .bus          (bus),
    .overrun_count(overrun_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t src_q [NP][$];
  beat_t exp_q [NP][$];
  int    dest_log[$];
  int    pulse_log[$];
  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  int    rec_port = -1;
  bit    rand_ready = 1'b0;
  bit    prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  logic [IW-1:0] prev_dest;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_src();
    for (int i = 0; i < int'(NP); i++) begin
      if (src_q[i].size() > 0) begin
        bus.s_tvalid[i]          = 1'b1;
        bus.s_tlast[i]           = src_q[i][0].last;
        bus.s_tdata[i*DW +: DW]  = src_q[i][0].data;
      end else begin
        bus.s_tvalid[i]          = 1'b0;
        bus.s_tlast[i]           = 1'b0;
        bus.s_tdata[i*DW +: DW]  = '0;
      end
    end
    bus.m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic load(input int port, input int len);
    for (int b = 0; b < len; b++) begin
      beat_t x;
      x.data = {$urandom(), $urandom()};
      x.last = (b == len - 1);
      src_q[port].push_back(x);
    end
  endtask

  // One clock: observe at the falling edge, update sources after the rising edge.
  task automatic cycle();
    logic [NP-1:0] hs;
    @(negedge clk);
    if (prev_stall) begin
      check("stall_valid", 64'(bus.m_tvalid), 64'd1);
      check("stall_data",  bus.m_tdata, prev_data);
      check("stall_last",  64'(bus.m_tlast), 64'(prev_last));
      check("stall_dest",  64'(bus.m_tdest), 64'(prev_dest));
    end
    if (bus.m_tvalid && bus.m_tready) begin
      int p;
      p = int'(bus.m_tdest);
      dest_log.push_back(p);
      if (rec_port >= 0) check("record_atomic", 64'(p), 64'(rec_port));
      rec_port = bus.m_tlast ? -1 : p;
      check("beat_expected", 64'(exp_q[p].size() != 0), 64'd1);
      if (exp_q[p].size() != 0) begin
        beat_t e;
        e = exp_q[p].pop_front();
        check("beat_data", bus.m_tdata, e.data);
        check("beat_last", 64'(bus.m_tlast), 64'(e.last));
      end
    end
    if (sample_req != '0) begin
      pulse_log.push_back(cyc);
      check("req_uniform", 64'(sample_req), 64'({NP{1'b1}}));
    end
    prev_stall = bus.m_tvalid && !bus.m_tready;
    prev_data  = bus.m_tdata;
    prev_last  = bus.m_tlast;
    prev_dest  = bus.m_tdest;
    hs = bus.s_tvalid & bus.s_tready;
    @(posedge clk);
    #1;
    for (int i = 0; i < int'(NP); i++) begin
      if (hs[i]) exp_q[i].push_back(src_q[i].pop_front());
    end
    drive_src();
    cyc++;
  endtask

  function automatic bit drained();
    for (int i = 0; i < int'(NP); i++) begin
      if (src_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic drain(input string tag, input int budget);
    for (int n = 0; n < budget && !drained(); n++) cycle();
    check(tag, 64'(drained()), 64'd1);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    enable        = 1'b0;
    time_running  = 1'b0;
    sample_period = '0;
    rand_ready    = 1'b0;
    for (int i = 0; i < int'(NP); i++) begin
      src_q[i].delete();
      exp_q[i].delete();
    end
    dest_log.delete();
    pulse_log.delete();
    prev_stall = 1'b0;
    rec_port   = -1;
    drive_src();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    int base;
    int total;

    // Reset state
    do_reset();
    check("rst_sample_req", 64'(sample_req), 64'd0);
    check("rst_m_tvalid",   64'(bus.m_tvalid), 64'd0);
    check("rst_m_tdata",    bus.m_tdata, 64'd0);
    check("rst_m_tlast",    64'(bus.m_tlast), 64'd0);
    check("rst_m_tdest",    64'(bus.m_tdest), 64'd0);
    check("rst_s_tready",   64'(bus.s_tready), 64'd0);
    check("rst_overrun",    64'(overrun_count), 64'd0);

    // Basic sampling, period 10
    enable = 1'b1; time_running = 1'b1; sample_period = 32'd10;
    repeat (45) cycle();
    check("basic_pulse_count", 64'(pulse_log.size()), 64'd4);
    foreach (pulse_log[j]) check("basic_pulse_at", 64'(pulse_log[j]), 64'(10 * (j + 1)));

    // Timer stopped: counter holds, no pulses
    pulse_log.delete();
    time_running = 1'b0;
    repeat (30) cycle();
    check("hold_no_pulse", 64'(pulse_log.size()), 64'd0);
    // Resume from held count 5: fires after 5 more cycles
    time_running = 1'b1;
    base = cyc;
    repeat (8) cycle();
    check("resume_pulse_count", 64'(pulse_log.size()), 64'd1);
    if (pulse_log.size() > 0) check("resume_pulse_at", 64'(pulse_log[0] - base), 64'd5);

    // Period reduced 10 -> 5 while count is 7
    do_reset();
    enable = 1'b1; time_running = 1'b1; sample_period = 32'd10;
    repeat (7) cycle();
    sample_period = 32'd5;
    base = cyc;
    repeat (20) cycle();
    check("chg_pulse_count", 64'(pulse_log.size()), 64'd4);
    foreach (pulse_log[j]) check("chg_pulse_at", 64'(pulse_log[j] - base), 64'(1 + 5 * j));

    // Overrun: nobody drains, every pulse after the first counts once
    do_reset();
    enable = 1'b1; time_running = 1'b1; sample_period = 32'd4;
    repeat (30) cycle();
    enable = 1'b0;
    repeat (3) cycle();
    check("ovr_pulses_seen", 64'(pulse_log.size() >= 2), 64'd1);
    check("ovr_count", 64'(overrun_count), 64'(pulse_log.size() - 1));

    // Overrun saturation with a pulse every cycle
    do_reset();
    enable = 1'b1; time_running = 1'b1; sample_period = 32'd1;
    repeat (65600) @(posedge clk);
    #1;
    check("ovr_saturated", 64'(overrun_count), 64'hFFFF);
    repeat (5) @(posedge clk);
    #1;
    check("ovr_no_wrap", 64'(overrun_count), 64'hFFFF);

    // Fairness: all ports busy with 3-beat records
    do_reset();
    for (int p = 0; p < int'(NP); p++) for (int r = 0; r < 4; r++) load(p, 3);
    drive_src();
    drain("fair_drained", 400);
    check("fair_beats", 64'(dest_log.size()), 64'(16 * 3));
    foreach (dest_log[j]) check("fair_dest", 64'(dest_log[j]), 64'((j / 3) % 4));

    // Backpressure with random records and random m_tready
    do_reset();
    rand_ready = 1'b1;
    total = 0;
    for (int p = 0; p < int'(NP); p++) begin
      int nrec;
      nrec = int'($urandom_range(1, 4));
      for (int r = 0; r < nrec; r++) begin
        int len;
        len = int'($urandom_range(1, 4));
        load(p, len);
        total += len;
      end
    end
    drive_src();
    drain("bp_drained", 2000);
    check("bp_beats", 64'(dest_log.size()), 64'(total));

    // Reset during beat 2 of a 3-beat record
    do_reset();
    load(2, 1);
    drive_src();
    drain("rr_setup_drained", 50);
    load(1, 3);
    drive_src();
    for (int n = 0; n < 20 && src_q[1].size() != 2; n++) cycle();
    check("mid_beat1_taken", 64'(src_q[1].size()), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_m_tvalid", 64'(bus.m_tvalid), 64'd0);
    check("mid_rst_s_tready", 64'(bus.s_tready), 64'd0);
    do_reset();
    for (int p = 0; p < int'(NP); p++) load(p, 1);
    drive_src();
    drain("post_rst_drained", 100);
    check("post_rst_beats", 64'(dest_log.size()), 64'(NP));
    foreach (dest_log[j]) check("post_rst_order", 64'(dest_log[j]), 64'(j));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
